// File: rtl/button_input.sv
// button_input: per-channel push-button conditioning.
// Each channel synchronizes a raw pad, debounces it with a stability counter,
// and classifies each press as a short click or a long press.
//
// Parameters:
//   N_BTN          number of independent button channels
//   DEBOUNCE_BITS  debounce counter width; a level change needs 2^DEBOUNCE_BITS stable cycles
//   LONG_BITS      hold counter width; a press held 2^LONG_BITS cycles is a long press
//   ACTIVE_LOW     1: pad reads 0 when pressed, 0: pad reads 1 when pressed
// Ports:
//   clki           system clock, rising edge
//   reset          asynchronous active-high reset
//   btn_in         raw button pads (asynchronous)
//   btn_level      debounced level, 1 = pressed
//   press_pulse    one-cycle pulse with the first pressed cycle
//   release_pulse  one-cycle pulse with the first released cycle
//   click_pulse    one-cycle pulse on release of a short press
//   long_press     one-cycle pulse when a press reaches the long threshold
module button_input #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned DEBOUNCE_BITS = 16,
  parameter int unsigned LONG_BITS     = 24,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic             clki,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] click_pulse,
  output logic [N_BTN-1:0] long_press
);

  localparam int unsigned DW = DEBOUNCE_BITS;
  localparam int unsigned LW = LONG_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          level;
    logic [DW-1:0] db_cnt;
    logic          raw_pressed_c;
    logic          flip_c;
    logic          rise_c;
    logic          fall_c;

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] hold_cnt;
    logic [LW-1:0] hold_nxt;
    logic          press_q;
    logic          release_q;
    logic          click_q;
    logic          long_q;
    logic          press_nxt;
    logic          release_nxt;
    logic          click_nxt;
    logic          long_nxt;

    assign raw_pressed_c = btn_in[i] ^ ACTIVE_LOW;

    // The level flips on the cycle the counter is saturated and still disagrees.
    assign flip_c = (s2 != level) && (db_cnt == '1);
    assign rise_c = flip_c & s2;
    assign fall_c = flip_c & ~s2;

    // Two-flop synchronizer and debounce counter.
    always_ff @(posedge clki or posedge reset) begin
      if (reset) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        level  <= 1'b0;
        db_cnt <= '0;
      end else begin
        s1 <= raw_pressed_c;
        s2 <= s1;
        if (s2 == level) begin
          db_cnt <= '0;
        end else if (db_cnt == '1) begin
          level  <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end
    end

    // Press classifier state, hold counter and registered pulses.
    always_ff @(posedge clki or posedge reset) begin
      if (reset) begin
        state     <= IDLE;
        hold_cnt  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        click_q   <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state     <= state_nxt;
        hold_cnt  <= hold_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        click_q   <= click_nxt;
        long_q    <= long_nxt;
      end
    end

    // Next state; the fall is tested before the threshold so a release wins the race.
    always_comb begin
      state_nxt   = state;
      hold_nxt    = hold_cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      click_nxt   = 1'b0;
      long_nxt    = 1'b0;
      unique case (state)
        IDLE: begin
          if (rise_c) begin
            state_nxt = PRESSED;
            hold_nxt  = '0;
            press_nxt = 1'b1;
          end
        end
        PRESSED: begin
          if (fall_c) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
            click_nxt   = 1'b1;
          end else if (hold_cnt == '1) begin
            state_nxt = HELD;
            long_nxt  = 1'b1;
          end else begin
            hold_nxt = hold_cnt + LW'(1);
          end
        end
        HELD: begin
          if (fall_c) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    assign btn_level[i]     = level;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign click_pulse[i]   = click_q;
    assign long_press[i]    = long_q;
  end

endmodule

// File: tb/tb_button_input.sv
// tb_button_input: directed bench for button_input with small counter widths
// (debounce 16 cycles, long press 64 cycles, active-low pads, 4 channels).
module tb_button_input;

  logic       clki = 1'b0;
  logic       reset;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] click_pulse;
  logic [3:0] long_press;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int n_press [4];
  int n_rel   [4];
  int n_click [4];
  int n_long  [4];
  int c_press [4];
  int c_long  [4];
  logic [3:0] lvl_seen;

  button_input #(
    .N_BTN        (4),
    .DEBOUNCE_BITS(4),
    .LONG_BITS    (6),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clki         (clki),
    .reset        (reset),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .click_pulse  (click_pulse),
    .long_press   (long_press)
  );

  always #5 clki = ~clki;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc      = 0;
    lvl_seen = '0;
    for (int i = 0; i < 4; i++) begin
      n_press[i] = 0;
      n_rel[i]   = 0;
      n_click[i] = 0;
      n_long[i]  = 0;
      c_press[i] = -1;
      c_long[i]  = -1;
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clki);
    #1;
    cyc++;
    lvl_seen = lvl_seen | btn_level;
    for (int i = 0; i < 4; i++) begin
      if (press_pulse[i]) begin
        n_press[i]++;
        if (c_press[i] < 0) c_press[i] = cyc;
      end
      if (release_pulse[i]) n_rel[i]++;
      if (click_pulse[i]) n_click[i]++;
      if (long_press[i]) begin
        n_long[i]++;
        if (c_long[i] < 0) c_long[i] = cyc;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 4'hF;
    clear_stats();
    run(3);
    check("rst_level",   32'(btn_level),     32'h0);
    check("rst_press",   32'(press_pulse),   32'h0);
    check("rst_release", 32'(release_pulse), 32'h0);
    check("rst_click",   32'(click_pulse),   32'h0);
    check("rst_long",    32'(long_press),    32'h0);
    reset = 1'b0;
    run(20);
    check("idle_level", 32'(lvl_seen), 32'h0);

    // Clean press/release on channel 0
    clear_stats();
    btn_in[0] = 1'b0;
    run(17);
    check("clean_level_early", 32'(btn_level), 32'h0);
    step();
    check("clean_level_rise", 32'(btn_level),   32'h1);
    check("clean_press",      32'(press_pulse), 32'h1);
    check("clean_press_cyc",  32'(c_press[0]),  32'd18);
    step();
    check("clean_press_once", 32'(press_pulse), 32'h0);
    run(11);
    btn_in[0] = 1'b1;
    run(17);
    check("clean_level_held", 32'(btn_level), 32'h1);
    step();
    check("clean_release",   32'(release_pulse), 32'h1);
    check("clean_click",     32'(click_pulse),   32'h1);
    check("clean_level_low", 32'(btn_level),     32'h0);
    run(5);
    check("clean_no_long",   32'(n_long[0]),  32'd0);
    check("clean_rel_count", 32'(n_rel[0]),   32'd1);
    check("clean_prs_count", 32'(n_press[0]), 32'd1);

    // Bounce on channel 1: never stable long enough
    clear_stats();
    btn_in[1] = 1'b0;
    run(10);
    btn_in[1] = 1'b1;
    run(3);
    btn_in[1] = 1'b0;
    run(15);
    btn_in[1] = 1'b1;
    run(30);
    check("bounce_level",   32'(lvl_seen[1]), 32'd0);
    check("bounce_press",   32'(n_press[1]),  32'd0);
    check("bounce_release", 32'(n_rel[1]),    32'd0);
    check("bounce_click",   32'(n_click[1]),  32'd0);

    // Long press on channel 2
    clear_stats();
    btn_in[2] = 1'b0;
    run(200);
    check("long_press_cyc", 32'(c_press[2]), 32'd18);
    check("long_cyc",       32'(c_long[2]),  32'd82);
    check("long_count",     32'(n_long[2]),  32'd1);
    check("long_no_click",  32'(n_click[2]), 32'd0);
    btn_in[2] = 1'b1;
    run(20);
    check("long_release",     32'(n_rel[2]),   32'd1);
    check("long_click_after", 32'(n_click[2]), 32'd0);
    check("long_level_low",   32'(btn_level),  32'h0);

    // Release lands on the cycle the hold counter is all-ones
    clear_stats();
    btn_in[0] = 1'b0;
    run(18);
    check("race_press", 32'(press_pulse), 32'h1);
    run(46);
    btn_in[0] = 1'b1;
    run(17);
    check("race_level_held", 32'(btn_level),  32'h1);
    check("race_long_early", 32'(long_press), 32'h0);
    step();
    check("race_release", 32'(release_pulse), 32'h1);
    check("race_click",   32'(click_pulse),   32'h1);
    check("race_no_long", 32'(long_press),    32'h0);
    run(5);
    check("race_long_count",  32'(n_long[0]),  32'd0);
    check("race_click_count", 32'(n_click[0]), 32'd1);

    // Reset while channel 3 is in HELD
    clear_stats();
    btn_in[3] = 1'b0;
    run(87);
    check("rmp_long",  32'(n_long[3]), 32'd1);
    check("rmp_level", 32'(btn_level), 32'h8);
    #2;
    reset = 1'b1;
    #1;
    check("rmp_level_clr",   32'(btn_level),     32'h0);
    check("rmp_press_clr",   32'(press_pulse),   32'h0);
    check("rmp_release_clr", 32'(release_pulse), 32'h0);
    check("rmp_click_clr",   32'(click_pulse),   32'h0);
    check("rmp_long_clr",    32'(long_press),    32'h0);
    clear_stats();
    run(3);
    reset = 1'b0;
    run(17);
    check("rmp_level_early", 32'(btn_level), 32'h0);
    step();
    check("rmp_press",      32'(press_pulse), 32'h8);
    check("rmp_no_release", 32'(n_rel[3]),    32'd0);

    // All channels pressed together
    btn_in = 4'hF;
    run(25);
    clear_stats();
    btn_in = 4'h0;
    run(17);
    check("conc_press_early", 32'(press_pulse), 32'h0);
    step();
    check("conc_press", 32'(press_pulse), 32'hF);
    check("conc_level", 32'(btn_level),   32'hF);
    btn_in = 4'hF;
    run(25);
    check("conc_release", 32'({n_rel[3] == 1, n_rel[2] == 1, n_rel[1] == 1, n_rel[0] == 1}), 32'hF);
    check("conc_level_low", 32'(btn_level), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_input.md
# button_input

Input-conditioning block for the board's user push-buttons. It feeds the LED pattern controllers, such as the scanner and mode logic, with clean, clock-synchronous button events. Each channel synchronizes a raw pad, debounces it with a stability counter, and classifies every press as a short click or a long press through a small per-channel state machine. All outputs are registered and sit in the `clki` domain.

## Interface
- `N_BTN`, default 4: number of independent button channels.
- `DEBOUNCE_BITS`, default 16: width of the debounce counter. An input must differ from the debounced level for 2^DEBOUNCE_BITS consecutive cycles before the level changes.
- `LONG_BITS`, default 24: width of the hold counter. A press held for 2^LONG_BITS cycles is a long press.
- `ACTIVE_LOW`, default 1: 1 means a pad reads 0 when pressed (pull-up buttons); 0 means it reads 1 when pressed.
- `clki` input, 1 bit: system clock; every flop is on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset. Assertion clears all state immediately; release is sampled on `clki`.
- `btn_in` input, N_BTN bits: raw button pads, asynchronous to `clki`.
- `btn_level` output, N_BTN bits: debounced level; 1 means pressed.
- `press_pulse` output, N_BTN bits: one-cycle pulse in the first cycle `btn_level` is 1.
- `release_pulse` output, N_BTN bits: one-cycle pulse in the first cycle `btn_level` is 0 after being 1.
- `click_pulse` output, N_BTN bits: one-cycle pulse on release of a press shorter than the long threshold.
- `long_press` output, N_BTN bits: one-cycle pulse when a press reaches the long threshold.

## Operation
Channels are fully independent. Per channel i:
- **Polarity:** `raw_pressed = btn_in[i] XOR ACTIVE_LOW`.
- **Synchronizer:** two flops, `s1` then `s2`. Both reset to 0 (not pressed). `s2` is the synchronized pressed value.
- **Debounce counter** (DEBOUNCE_BITS wide, reset 0):
  - If `s2 == btn_level[i]`, the counter clears to 0.
  - Otherwise it increments by 1.
  - On a cycle where the counter is all-ones and `s2 != btn_level[i]`: `btn_level[i] <= s2` and the counter clears to 0. The counter never wraps.
- **FSM** (reset state IDLE):
  - **IDLE:** `btn_level` = 0. On the rise of `btn_level`, go to PRESSED and clear the hold counter. `press_pulse` is asserted together with the first `btn_level` = 1 cycle.
  - **PRESSED:** the hold counter (LONG_BITS wide) increments each cycle.
    - When it is all-ones: go to HELD and pulse `long_press` on the next cycle.
    - If `btn_level` falls first: go to IDLE and pulse `release_pulse` and `click_pulse` in the same cycle.
  - **HELD:** the hold counter is frozen. When `btn_level` falls: go to IDLE and pulse `release_pulse` only; `click_pulse` stays 0.
- All pulses are exactly one cycle wide and never asserted in back-to-back cycles on the same channel.

## Timing
- **Reset:** every output is 0, counters are 0, the FSM is IDLE and the synchronizers are 0, all immediately on `reset` assertion.
- **Pad to level:** a clean pad change reaches `btn_level` 2 + 2^DEBOUNCE_BITS cycles after the first `clki` edge that samples it.
- **Glitch rejection:** any bounce shorter than 2^DEBOUNCE_BITS cycles returns the counter to 0 and produces no output change.
- **Long press:** `long_press` asserts 2^LONG_BITS cycles after the `press_pulse` cycle.
- **Release at the threshold:** if `btn_level` falls in the same cycle the hold counter is all-ones, the release wins. The result is `release_pulse` + `click_pulse`, with no `long_press`.
- **Reset mid-press:** if the button is held through reset release, `btn_level` rises 2 + 2^DEBOUNCE_BITS cycles after release, with a fresh `press_pulse`. No `release_pulse` is ever generated by reset.
- **Multiple channels:** channels may pulse in the same cycle without interaction.

## Test plan
Use `DEBOUNCE_BITS`=4, `LONG_BITS`=6, `ACTIVE_LOW`=1, `N_BTN`=4.
- **Clean press/release:**
  - Drive `btn_in[0]` 1→0 → `btn_level[0]`=1 and `press_pulse[0]`=1 for one cycle, exactly 18 cycles later.
  - Drive it back to 1 after 30 cycles → `release_pulse[0]` and `click_pulse[0]` pulse together; `long_press[0]` stays 0.
- **Bounce:** toggle `btn_in[1]` low for 10 cycles, high for 3, low for 15, then high → `btn_level[1]` and all pulses on channel 1 stay 0 throughout.
- **Long press:** hold `btn_in[2]` low for 200 cycles → `long_press[2]` pulses once, 64 cycles after `press_pulse[2]`. Release → `release_pulse[2]` only, with `click_pulse[2]`=0.
- **Threshold race:** time the release so `btn_level` falls in the cycle the hold counter is 63 → `click_pulse` + `release_pulse`, no `long_press`.
- **Reset mid-press:**
  - Hold `btn_in[3]` low and pulse `reset` while in HELD → all outputs 0 immediately, with no `release_pulse`.
  - Then `press_pulse[3]` fires 18 cycles after reset release.
- **Concurrency:** press all four channels in the same cycle → four `press_pulse` bits assert in the same cycle.
